// File: rtl/pwm_led_pkg.sv
// Shared types and default constants for the LED breathing PWM generator.
package pwm_led_pkg;

  // Default PWM counter width: period of 2^8 clocks.
  localparam int unsigned PWM_CNT_W_DEF = 8;
  // Default number of complete PWM periods each duty value is held for.
  localparam int unsigned PWM_STEP_PERIODS_DEF = 4;

  // Sweep direction of the duty triangle wave.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/pwm_led_breather_if.sv
// LED output bundle of the breather, with observation of the duty and sweep direction.
interface pwm_led_breather_if
  import pwm_led_pkg::*;
#(
  parameter int unsigned CNT_W = PWM_CNT_W_DEF
) ();

  logic             LED;
  logic [CNT_W-1:0] pwm_inp;
  dir_t             dir;

  modport master (output LED, output pwm_inp, output dir);
  modport slave  (input  LED, input  pwm_inp, input  dir);

endinterface

// File: rtl/pwm_led_breather_core.sv
// PWM core: free-running period counter plus registered compare against the duty.
// Build option PWM_LED_ACTIVE_LOW_EN: LED resets to 1 and carries the inverted compare.
module pwm_core #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_led,
  output logic             o_period_end
);

  localparam logic [CNT_W-1:0] CntMax = '1;

`ifdef PWM_LED_ACTIVE_LOW_EN
  localparam logic LedRst = 1'b1;
`else
  localparam logic LedRst = 1'b0;
`endif

  logic [CNT_W-1:0] r_cnt;
  logic             r_led;
  logic             w_led_next;

  assign o_period_end = (r_cnt == CntMax);
  assign o_led        = r_led;

  // Compare uses the pre-edge counter and duty, giving one clock of latency.
  always_comb begin
`ifdef PWM_LED_ACTIVE_LOW_EN
    w_led_next = ~(r_cnt < i_duty);
`else
    w_led_next = (r_cnt < i_duty);
`endif
  end

  // Counter wraps naturally modulo 2^CNT_W; LED is the registered compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_led <= LedRst;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_led <= w_led_next;
    end
  end

endmodule

// File: rtl/pwm_led_breather.sv
// LED breathing generator: prescaled triangle sweep of the PWM duty.
// Build option PWM_LED_ACTIVE_LOW_EN selects active-low LED drive inside pwm_core.
module pwm_led_breather
  import pwm_led_pkg::*;
#(
  parameter int unsigned CNT_W        = PWM_CNT_W_DEF,
  parameter int unsigned STEP_PERIODS = PWM_STEP_PERIODS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  pwm_led_breather_if.master  bus
);

  // Keep the prescaler at least one bit wide so STEP_PERIODS=1 still elaborates.
  localparam int unsigned      PsW    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PsW-1:0]   PsLast = PsW'(STEP_PERIODS - 1);
  localparam logic [CNT_W-1:0] InpMax = '1;

  logic [PsW-1:0]   r_prescale;
  logic [CNT_W-1:0] r_inp;
  logic [CNT_W-1:0] w_inp_next;
  logic [CNT_W-1:0] w_inp_inc;
  logic [CNT_W-1:0] w_inp_dec;
  dir_t             r_dir;
  dir_t             w_dir_next;
  logic             w_period_end;
  logic             w_step;
  logic             w_led;

  pwm_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk          (clk),
    .reset        (reset),
    .i_duty       (r_inp),
    .o_led        (w_led),
    .o_period_end (w_period_end)
  );

  assign w_step    = w_period_end && (r_prescale == PsLast);
  assign w_inp_inc = r_inp + 1'b1;
  assign w_inp_dec = r_inp - 1'b1;

  // Prescaler counts completed PWM periods and wraps on each duty step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prescale <= '0;
    end else if (w_period_end) begin
      r_prescale <= w_step ? '0 : r_prescale + 1'b1;
    end
  end

  // Direction state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dir <= DIR_UP;
    end else begin
      r_dir <= w_dir_next;
    end
  end

  // Turn around as the duty lands on an endpoint, so each endpoint is held a full step.
  always_comb begin
    w_dir_next = r_dir;
    if (w_step) begin
      unique case (r_dir)
        DIR_UP:   if (w_inp_inc == InpMax) w_dir_next = DIR_DOWN;
        DIR_DOWN: if (w_inp_dec == '0)     w_dir_next = DIR_UP;
        default:  w_dir_next = DIR_UP;
      endcase
    end
  end

  // Duty moves one count per step in the current direction.
  always_comb begin
    w_inp_next = r_inp;
    if (w_step) begin
      w_inp_next = (r_dir == DIR_UP) ? w_inp_inc : w_inp_dec;
    end
  end

  // Duty register; only changes at a period boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inp <= '0;
    end else begin
      r_inp <= w_inp_next;
    end
  end

  // Drive the interface.
  always_comb begin
    bus.LED     = w_led;
    bus.pwm_inp = r_inp;
    bus.dir     = r_dir;
  end

endmodule

// File: tb/tb_pwm_led_breather.sv
// Self-checking bench for pwm_led_breather at CNT_W=4, STEP_PERIODS=2.
// Honours PWM_LED_ACTIVE_LOW_EN when the whole bundle is built with it.
module tb_pwm_led_breather;
  import pwm_led_pkg::*;

  localparam int unsigned CW     = 4;
  localparam int unsigned SP     = 2;
  localparam int          PERIOD = 1 << CW;        // 16 clocks
  localparam int          MAXV   = PERIOD - 1;     // 15
  localparam int          STEPC  = PERIOD * SP;    // clocks per duty value
  localparam int          TRI    = 2 * MAXV;       // duty values per triangle

`ifdef PWM_LED_ACTIVE_LOW_EN
  localparam logic LED_OFF = 1'b1;
`else
  localparam logic LED_OFF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   t = 0;  // rising edges since last reset release

  pwm_led_breather_if #(.CNT_W(CW)) bus ();

  pwm_led_breather #(
    .CNT_W        (CW),
    .STEP_PERIODS (SP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: duty after n edges is a triangle over the step index n/STEPC.
  function automatic int exp_duty(input int n);
    int p;
    p = (n / STEPC) % TRI;
    return (p <= MAXV) ? p : TRI - p;
  endfunction

  function automatic logic exp_down(input int n);
    return ((n / STEPC) % TRI) >= MAXV;
  endfunction

  // LED after n edges reflects counter and duty as they were one edge earlier.
  function automatic logic exp_led(input int n);
    logic on;
    if (n == 0) on = 1'b0;
    else        on = ((n - 1) % PERIOD) < exp_duty(n - 1);
    return on ^ LED_OFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    t++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.LED !== LED_OFF || bus.pwm_inp !== 4'd0 || bus.dir !== DIR_UP) begin
        errors++;
        $display("FAIL reset_hold: LED=%b inp=%0d dir=%b, want LED=%b inp=0 dir=0",
                 bus.LED, bus.pwm_inp, bus.dir, LED_OFF);
      end
    end
    reset = 1'b1;
    t = 0;
  endtask

  // Advance to edge count `target`, comparing every cycle against the reference.
  task automatic test_sweep_to(input int target, input string tag);
    while (t < target) begin
      tick();
      checks++;
      if (bus.LED !== exp_led(t) || bus.pwm_inp !== CW'(exp_duty(t))
          || (bus.dir == DIR_DOWN) !== exp_down(t)) begin
        errors++;
        $display("FAIL %s t=%0d: LED=%b inp=%0d dir=%b, want LED=%b inp=%0d dir=%b",
                 tag, t, bus.LED, bus.pwm_inp, bus.dir, exp_led(t), exp_duty(t), exp_down(t));
      end
    end
  endtask

  // Count LED-on clocks across one full period starting at the next edge.
  task automatic count_on(output int on);
    on = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      if (bus.LED !== LED_OFF) on++;
    end
  endtask

  task automatic test_duty_zero();
    int on;
    on = 0;
    for (int i = 0; i < STEPC; i++) begin
      tick();
      if (bus.LED !== LED_OFF) on++;
    end
    checks++;
    if (on != 0) begin
      errors++;
      $display("FAIL duty0_dark: on=%0d want 0", on);
    end
    checks++;
    if (bus.pwm_inp !== 4'd1) begin
      errors++;
      $display("FAIL first_step: inp=%0d want 1", bus.pwm_inp);
    end
  endtask

  task automatic test_duty_one();
    int on;
    count_on(on);
    checks++;
    if (on != 1) begin
      errors++;
      $display("FAIL duty1_count: on=%0d want 1", on);
    end
    test_sweep_to(2 * STEPC, "duty1_track");
  endtask

  task automatic test_peak();
    int on;
    test_sweep_to(MAXV * STEPC, "rise_track");
    checks++;
    if (bus.pwm_inp !== 4'd15 || bus.dir !== DIR_DOWN) begin
      errors++;
      $display("FAIL peak: inp=%0d dir=%b want 15/1", bus.pwm_inp, bus.dir);
    end
    count_on(on);
    checks++;
    if (on != 15) begin
      errors++;
      $display("FAIL peak_count: on=%0d want 15", on);
    end
    test_sweep_to((MAXV + 1) * STEPC, "peak_hold");
    checks++;
    if (bus.pwm_inp !== 4'd14 || bus.dir !== DIR_DOWN) begin
      errors++;
      $display("FAIL after_peak: inp=%0d dir=%b want 14/1", bus.pwm_inp, bus.dir);
    end
    count_on(on);
    checks++;
    if (on != 14) begin
      errors++;
      $display("FAIL duty14_count: on=%0d want 14", on);
    end
  endtask

  task automatic test_turnaround();
    int on;
    test_sweep_to(TRI * STEPC, "fall_track");
    checks++;
    if (bus.pwm_inp !== 4'd0 || bus.dir !== DIR_UP) begin
      errors++;
      $display("FAIL bottom: inp=%0d dir=%b want 0/0", bus.pwm_inp, bus.dir);
    end
    on = 0;
    for (int i = 0; i < STEPC; i++) begin
      tick();
      if (bus.LED !== LED_OFF) on++;
    end
    checks++;
    if (on != 0) begin
      errors++;
      $display("FAIL bottom_dark: on=%0d want 0", on);
    end
    checks++;
    if (bus.pwm_inp !== 4'd1 || bus.dir !== DIR_UP) begin
      errors++;
      $display("FAIL rebound: inp=%0d dir=%b want 1/0", bus.pwm_inp, bus.dir);
    end
  endtask

  // Drop reset between edges at a chosen point, then check the restart.
  task automatic test_async_reset(input int drop_at, input string tag);
    int hold;
    test_sweep_to(drop_at, tag);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.LED !== LED_OFF || bus.pwm_inp !== 4'd0 || bus.dir !== DIR_UP) begin
      errors++;
      $display("FAIL %s_async: LED=%b inp=%0d dir=%b want LED=%b inp=0 dir=0",
               tag, bus.LED, bus.pwm_inp, bus.dir, LED_OFF);
    end
    hold = $urandom_range(1, 4);
    repeat (hold) @(negedge clk);
    checks++;
    if (bus.LED !== LED_OFF || bus.pwm_inp !== 4'd0) begin
      errors++;
      $display("FAIL %s_held: LED=%b inp=%0d want LED=%b inp=0", tag, bus.LED, bus.pwm_inp, LED_OFF);
    end
    reset = 1'b1;
    t = 0;
    test_sweep_to($urandom_range(STEPC + 10, 4 * STEPC), {tag, "_restart"});
  endtask

  initial begin
    test_reset();
    test_duty_zero();
    test_duty_one();
    test_peak();
    test_turnaround();
    // Duty 7 on the second upward ramp, at a random point inside its step.
    test_async_reset((TRI + 7) * STEPC + $urandom_range(1, STEPC - 2), "rst_duty7");
    for (int r = 0; r < 3; r++) begin
      test_async_reset(t + $urandom_range(5, 20 * STEPC), "rst_rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Whole run is a few thousand clocks; this only trips on a stuck bench.
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pwm_led_breather.md
Name: pwm_led_breather

Overview:
- LED "breathing" PWM generator. A free-running period counter (pwm_cnt) is compared against a duty register (pwm_inp) to drive one LED.
- The duty value sweeps as a triangle wave 0 -> MAX -> 0 -> ..., so LED brightness ramps up and down continuously.
- Standalone leaf block with no data inputs; sits directly on a board LED pin.

Parameters:
- CNT_W, 8: width of pwm_cnt and pwm_inp. PWM period = 2^CNT_W clocks; MAX = 2^CNT_W-1.
- STEP_PERIODS, 4: number of complete PWM periods between duty updates (>=1).

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- LED  output  1  registered PWM output.

Behaviour:
- Reset (reset==0, asynchronous, no clock needed):
  - pwm_cnt=0, pwm_inp=0, prescale count=0, dir=UP, LED=0.
  - All state holds while reset is low.
  - The first clock after release counts normally.
- pwm_cnt: increments by 1 each clock, wraps MAX->0 (modulo 2^CNT_W).
- period_end = (pwm_cnt==MAX).
- Prescaler: counts period_end events 0..STEP_PERIODS-1. step = period_end && prescale==STEP_PERIODS-1; prescale wraps to 0 on step.
- Duty update on step only, so duty never changes mid-period:
  - dir==UP: pwm_inp <= pwm_inp+1; if pwm_inp+1==MAX then dir <= DOWN.
  - dir==DOWN: pwm_inp <= pwm_inp-1; if pwm_inp-1==0 then dir <= UP.
  - Sequence: 0,1,...,MAX,MAX-1,...,1,0,1,... Each value holds exactly STEP_PERIODS periods, including endpoints. Never wraps past 0 or MAX.
- LED register: LED <= (pwm_cnt < pwm_inp), using the pre-edge values, so one clock of latency.
  - duty 0 -> LED constantly 0.
  - duty d -> LED high for exactly d of every 2^CNT_W clocks, contiguous, beginning the cycle after pwm_cnt==0.
  - duty MAX -> low 1 clock per period.
- Direction FSM: two states, UP and DOWN. Transitions only on step.
- Reset mid-operation: immediate return to reset values; sweep restarts at duty 0, UP.
- All counters unsigned; comparison unsigned, CNT_W bits wide.

Optional Feature:
- Macro: PWM_LED_ACTIVE_LOW_EN.
- Defined: LED register resets to 1 and is loaded with the inverse, ~(pwm_cnt < pwm_inp), for active-low LED wiring.
- Undefined: behaviour exactly as above.
- Counters and FSM are identical in both builds.

Decomposition:
- Package pwm_led_pkg holds:
  - dir_t enum {DIR_UP, DIR_DOWN}.
  - Default constants PWM_CNT_W_DEF=8 and PWM_STEP_PERIODS_DEF=4.
- One sub-module, pwm_core: holds pwm_cnt and the registered LED compare. It takes duty and outputs LED and period_end.
- The top keeps the prescaler, direction FSM and pwm_inp.

Test Plan (CNT_W=4, STEP_PERIODS=2, period 16 clocks):
- Reset low for 3 clocks then high -> LED=0, pwm_inp=0 throughout reset. LED stays 0 for first 32 clocks (duty 0 for 2 periods).
- Run to first step -> pwm_inp=1 after clock 32. In each following period LED is high exactly 1 clock, the clock after pwm_cnt==0.
- Run 15 steps -> pwm_inp=15, dir=DOWN; LED high 15 of 16 clocks. Next step -> pwm_inp=14, LED high 14 clocks.
- Continue to duty 0 -> LED low for full 32 clocks. Next step -> pwm_inp=1, dir=UP (triangle turnaround at 0).
- Drop reset asynchronously mid-period at duty 7 (between edges) -> LED, pwm_cnt, pwm_inp go 0 immediately. After release the sweep restarts from 0.
- Build with PWM_LED_ACTIVE_LOW_EN, repeat duty-1 check -> LED=1 in reset and low exactly 1 clock per period.
